// File: rtl/pipeif_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues one request at a time to a
// variable-latency memory, and buffers returned instructions in a small queue.
module pipeif_queue #(
  parameter int              WIDTH    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       pcsource,
  input  logic [WIDTH-1:0] bpc,
  input  logic [WIDTH-1:0] rpc,
  input  logic [WIDTH-1:0] jpc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             id_ready,
  output logic             if_valid,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc4
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] fpc_reg, fpc_next;
  logic [WIDTH-1:0] drain_reg, drain_next;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg;

  logic [WIDTH-1:0] pc_mem   [DEPTH];
  logic [WIDTH-1:0] inst_mem [DEPTH];

  logic             redirect;
  logic [WIDTH-1:0] target;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count_after_push;

  assign redirect = (pcsource != 2'b00);
  assign pop      = (count_reg != '0) && id_ready;
  assign count_after_push = count_reg + CW'(1) - (pop ? CW'(1) : CW'(0));

  always_comb begin
    target = bpc;
    case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = rpc;
      2'b11:   target = jpc;
      default: target = bpc;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    fpc_next   = fpc_reg;
    drain_next = drain_reg;
    push       = 1'b0;
    imem_req   = 1'b0;
    imem_addr  = fpc_reg;
    case (state_reg)
      IDLE: begin
        if (redirect) begin
          fpc_next = target;
        end else if (count_reg < DEPTH_C) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          fpc_next = target;
          if (imem_ack) begin
            state_next = FETCH;
          end else begin
            // The in-flight request must still complete; remember its address.
            state_next = DRAIN;
            drain_next = fpc_reg;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fpc_next   = fpc_reg + WIDTH'(4);
          state_next = (count_after_push < DEPTH_C) ? FETCH : IDLE;
        end
      end
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_reg;
        if (redirect) begin
          fpc_next = target;
        end
        if (imem_ack) begin
          state_next = FETCH;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      fpc_reg    <= RESET_PC;
      drain_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      fpc_reg   <= fpc_next;
      drain_reg <= drain_next;
      if (redirect) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CW'(1);
          2'b01:   count_reg <= count_reg - CW'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem[wr_ptr_reg]   <= fpc_reg;
      inst_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

  assign if_valid = (count_reg != '0);
  assign inst     = if_valid ? inst_mem[rd_ptr_reg] : '0;
  assign pc       = if_valid ? pc_mem[rd_ptr_reg] : '0;
  assign pc4      = if_valid ? (pc_mem[rd_ptr_reg] + WIDTH'(4)) : '0;

endmodule

// File: doc/pipeif_queue.md
Name: pipeif_queue

Overview:
- Parametrised next-generation instruction-fetch stage for the 5-stage pipeline.
- Owns the fetch PC register and selects the next PC from sequential, branch, register-jump and jump targets.
- Issues requests to a variable-latency instruction memory with a req/ack handshake.
- Buffers returned instructions in a DEPTH-entry queue so the ID stage can stall without blocking fetch.

Parameters:
WIDTH, 32, address and instruction width in bits
DEPTH, 4, fetch-queue entries; power of 2, minimum 2
RESET_PC, 0, fetch address loaded on reset

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
pcsource  in  2  next-PC select from ID: 00 sequential, 01 bpc, 10 rpc, 11 jpc
bpc  in  WIDTH  branch target
rpc  in  WIDTH  register-jump target
jpc  in  WIDTH  jump target
imem_req  out  1  memory request valid
imem_addr  out  WIDTH  request address
imem_ack  in  1  request complete; imem_rdata valid this cycle
imem_rdata  in  WIDTH  returned instruction
id_ready  in  1  ID stage accepts the head entry this cycle
if_valid  out  1  queue head valid
inst  out  WIDTH  head instruction
pc  out  WIDTH  head instruction address
pc4  out  WIDTH  head address + 4

Behaviour:
- Reset (synchronous, active-high) values:
  - fpc = RESET_PC; queue empty; state = IDLE.
  - imem_req = 0, if_valid = 0; inst, pc, pc4 = 0.
- redirect = (pcsource != 00). Target: 01 → bpc, 10 → rpc, 11 → jpc. With 00, fpc advances only through fetch.
- Arithmetic: fpc + 4 and pc4 are modulo 2^WIDTH (0xFFFFFFFC + 4 = 0x00000000). No alignment check.
- State machine:
  - IDLE: imem_req = 0.
    - redirect → fpc = target, stay in IDLE.
    - Otherwise, count < DEPTH → FETCH.
  - FETCH: imem_req = 1, imem_addr = fpc. Both are held stable until ack.
    - ack and no redirect: push {fpc, rdata}; fpc += 4. Then go to FETCH if post-update count < DEPTH, else IDLE.
    - redirect and ack in the same cycle: rdata discarded; fpc = target; go to FETCH.
    - redirect without ack: fpc = target; go to DRAIN.
  - DRAIN: imem_req = 1, imem_addr = the abandoned address (held in a separate register).
    - On ack: data discarded; go to FETCH.
    - A further redirect while in DRAIN overwrites fpc; stay in DRAIN.
- One request outstanding at most. A new request issues only when count < DEPTH, so the queue never overflows.
- Queue:
  - if_valid = (count != 0). inst, pc, pc4 reflect the head entry and are 0 when empty.
  - Pop when if_valid && id_ready. Push and pop in the same cycle leave count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- redirect flushes the queue: count = 0, pointers reset. Redirect overrides any pop or push in that cycle.
- Latency:
  - Minimum request-to-if_valid latency is 1 cycle after ack; the pushed entry is visible the cycle after ack.
  - Redirect to first target request: 1 cycle when not draining.
- Empty queue with id_ready = 1: no effect.
- Full queue: fetch pauses in IDLE until a pop frees an entry.
- Reset mid-request clears state immediately. The memory shares this reset, so no stale ack arrives afterwards.

Test Plan:
- Reset release, RESET_PC = 0x00400000, ack after 1 cycle, id_ready = 1 → imem_addr sequence 0x00400000, 0x00400004, 0x00400008. Outputs match: inst = rdata, pc4 = pc + 4.
- id_ready = 0, DEPTH = 4, immediate acks → exactly 4 pushes, then imem_req = 0. After one pop, exactly one more request issues at the next address.
- Redirect while in FETCH with ack delayed 3 cycles, pcsource = 01, bpc = 0x00400100:
  - if_valid drops next cycle.
  - Old address is held until ack; its data is discarded.
  - Next request address = 0x00400100.
- Redirect coinciding with ack and pop, pcsource = 11, jpc = 0x00000040 → ack data not queued, queue empty, next imem_addr = 0x00000040.
- pcsource = 10, rpc = 0xFFFFFFFC, then sequential fetch → second address 0x00000000, and that entry's pc4 = 0x00000004.
- Assert reset while in DRAIN with 2 queued entries → next cycle: imem_req = 0, if_valid = 0. Fetch then restarts at RESET_PC.
